arbitro_2: RTL and testbench
============================

Name: arbitro_2

Overview:
Egress-side arbiter. Drains the four destination FIFOs (one per dest, filled by the ingress arbiter's Push) onto a single registered output stream. Service order is weighted round-robin, per-channel weights defaulting to 4:3:2:1. Pops are throttled by downstream back-pressure.

Parameters:
DATA_WIDTH, 8, width of one FIFO word and of data_out
W0, 4, consecutive pops granted to FIFO0 per turn (0 treated as 1)
W1, 3, same for FIFO1
W2, 2, same for FIFO2
W3, 1, same for FIFO3

Ports:
clk  input  1  single clock, all state on posedge
reset_L  input  1  asynchronous, active-low reset
FIFO_empty  input  4  empty flags of destination FIFOs 3..0
FIFO_data_out  input  4*DATA_WIDTH  read data; FIFOn at bits [n*DATA_WIDTH +: DATA_WIDTH]; valid the cycle after that FIFO's pop
out_almost_full  input  1  downstream back-pressure; 1 = no new pops
Pops  output  4  one-hot pop strobes, combinational from state and inputs
data_out  output  DATA_WIDTH  registered output word
valid_out  output  1  registered; data_out holds a new word this cycle
idle  output  1  registered; 1 when all FIFOs are empty and no word is in flight

Behaviour:
- Reset (reset_L=0, async): Pops=0, data_out=0, valid_out=0, idle=1; pointer g=0, credit cnt=0; pipeline valid/select cleared. Pops is forced to 0 combinationally while reset_L=0.
- Selection (combinational): c = first index with FIFO_empty[i]=0, searching g, g+1, g+2, g+3 (mod 4).
- Pop rule: Pops = onehot(c) iff reset_L=1, out_almost_full=0, and at least one FIFO is non-empty; otherwise Pops=0.
- Credit update on a pop cycle:
  - base = (c==g) ? cnt : 0
  - if base+1 >= W_c: g <= (c+1) mod 4, cnt <= 0
  - else: g <= c, cnt <= base+1
- No pop (all empty or back-pressure): g and cnt hold.
- cnt width is enough to hold max(W)-1.
- Pipeline:
  - Stage1 at pop edge: p_vld <= |Pops, p_sel <= c.
  - Stage2 at next edge: valid_out <= p_vld; if p_vld, data_out <= FIFO_data_out slice p_sel, else data_out holds.
- Latency: word popped in cycle N appears on data_out/valid_out in cycle N+2.
- Throughput: one word per cycle while any FIFO is non-empty and out_almost_full=0.
- Back-pressure: out_almost_full=1 stops new pops in the same cycle. At most 2 in-flight words still complete. The downstream threshold must reserve 2 entries.
- Empty flag is sampled combinationally, so a single-word FIFO is popped exactly once.
- idle <= (&FIFO_empty) & ~p_vld & ~|Pops.
- Reset asserted mid-burst: in-flight words are discarded and valid_out drops immediately. After release, service restarts at FIFO0 with cnt=0.

Test Plan:
- All four FIFOs preloaded with 12 words (tag = channel<<4 | seq), out_almost_full=0 -> popped index sequence 0,0,0,0,1,1,1,2,2,3 repeating. First valid_out is 2 cycles after the first Pops. data_out tags appear in the same order with no gaps.
- Only FIFO2 non-empty with 5 words -> Pops=4'b0100 for 5 consecutive cycles, then 0. valid_out high 5 cycles. idle=1 two cycles after the last pop.
- FIFO0 holds 1 word, FIFO1 holds 3 words -> pops 0,1,1,1. FIFO0 is popped once only. No pop is issued while the target FIFO is empty.
- Steady four-FIFO traffic with out_almost_full=1 raised for 4 cycles after the 3rd pop -> Pops=0 that same cycle. Exactly 2 further valid_out words. After release, resume at FIFO0 with its 4th credit (cnt=3 preserved).
- reset_L pulsed low for 1 cycle mid-burst (asynchronous, between edges) -> Pops, valid_out, and data_out go to 0 immediately. First post-reset pop targets the lowest non-empty index starting at 0.
- Parameters W0=1, W1=1, W2=1, W3=1, all FIFOs full -> strict rotation 0,1,2,3,0,...

Source files
------------

// File: rtl/arbitro_2.sv
// arbitro_2: weighted round-robin egress arbiter draining four FIFOs into one registered stream
module arbitro_2 #(
  parameter int DATA_WIDTH = 8,
  parameter int W0 = 4,
  parameter int W1 = 3,
  parameter int W2 = 2,
  parameter int W3 = 1
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [3:0]                FIFO_empty,
  input  logic [4*DATA_WIDTH-1:0]   FIFO_data_out,
  input  logic                      out_almost_full,
  output logic [3:0]                Pops,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      valid_out,
  output logic                      idle
);
  localparam int E0 = W0 < 1 ? 1 : W0;
  localparam int E1 = W1 < 1 ? 1 : W1;
  localparam int E2 = W2 < 1 ? 1 : W2;
  localparam int E3 = W3 < 1 ? 1 : W3;
  localparam int M01 = E0 > E1 ? E0 : E1;
  localparam int M23 = E2 > E3 ? E2 : E3;
  localparam int EM = M01 > M23 ? M01 : M23;
  localparam int CW = EM > 1 ? $clog2(EM) : 1;
  logic [1:0]            g_q, g_d, c, p_sel_q, p_sel_d;
  logic [CW-1:0]         cnt_q, cnt_d, base;
  logic [31:0]           nxt, wc;
  logic                  pop, done, p_vld_q, p_vld_d, valid_q, valid_d, idle_q, idle_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  always_comb begin
    c = !FIFO_empty[g_q] ? g_q :
        !FIFO_empty[g_q + 2'd1] ? g_q + 2'd1 :
        !FIFO_empty[g_q + 2'd2] ? g_q + 2'd2 : g_q + 2'd3;
    pop = reset_L & ~out_almost_full & ~&FIFO_empty;
    Pops = pop ? 4'b0001 << c : 4'b0000;
    base = (c == g_q) ? cnt_q : '0;
    wc = c == 2'd0 ? 32'(E0) : c == 2'd1 ? 32'(E1) : c == 2'd2 ? 32'(E2) : 32'(E3);
    nxt = 32'(base) + 32'd1;
    done = nxt >= wc;
    g_d = !pop ? g_q : done ? c + 2'd1 : c;
    cnt_d = !pop ? cnt_q : done ? '0 : nxt[CW-1:0];
    p_vld_d = pop;
    p_sel_d = c;
    valid_d = p_vld_q;
    data_d = p_vld_q ? FIFO_data_out[p_sel_q*DATA_WIDTH +: DATA_WIDTH] : data_q;
    // idle must also see the word about to be popped, not just empty flags
    idle_d = &FIFO_empty & ~p_vld_q & ~pop;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      g_q <= '0;
      cnt_q <= '0;
      p_vld_q <= 1'b0;
      p_sel_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      idle_q <= 1'b1;
    end else begin
      g_q <= g_d;
      cnt_q <= cnt_d;
      p_vld_q <= p_vld_d;
      p_sel_q <= p_sel_d;
      valid_q <= valid_d;
      data_q <= data_d;
      idle_q <= idle_d;
    end
  end
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign idle = idle_q;
endmodule

// File: tb/tb_arbitro_2.sv
// tb_arbitro_2: scoreboard bench for arbitro_2 with behavioural FIFO models
module tb_arbitro_2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset_L = 1'b1, afull = 1'b0;
  logic [3:0]  emp = 4'hF, e1 = 4'hF, pops, pops1;
  logic [31:0] fdo = '0;
  logic [7:0]  dout, dout1;
  logic        vout, vout1, idl, idl1;
  arbitro_2 u_dut (
    .clk(clk), .reset_L(reset_L), .FIFO_empty(emp), .FIFO_data_out(fdo),
    .out_almost_full(afull), .Pops(pops), .data_out(dout), .valid_out(vout), .idle(idl)
  );
  arbitro_2 #(.W0(1), .W1(1), .W2(1), .W3(1)) u_w1 (
    .clk(clk), .reset_L(reset_L), .FIFO_empty(e1), .FIFO_data_out(32'h0),
    .out_almost_full(1'b0), .Pops(pops1), .data_out(dout1), .valid_out(vout1), .idle(idl1)
  );
  int n_vec = 0, n_err = 0;
  logic [7:0] fq [4][$];
  logic [7:0] sb [$];
  int hist [$];
  int m_g = 0, m_cnt = 0;
  logic m_v1 = 1'b0, m_v2 = 1'b0;
  int wt [4] = '{4, 3, 2, 1};
  int exp1 [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load(input int ch, input int n, input int base);
    for (int i = 0; i < n; i++) fq[ch].push_back(8'(base + i));
    emp[ch] = 1'b0;
  endtask
  task automatic rst_pulse();
    #3 reset_L = 1'b0;
    #1;
    chk("rst_pops", pops, 0);
    chk("rst_valid", vout, 0);
    chk("rst_data", dout, 0);
    chk("rst_idle", idl, 1);
    @(posedge clk);
    #1;
    chk("rst_pops1", pops1, 0);
    reset_L = 1'b1;
    m_g = 0;
    m_cnt = 0;
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    sb.delete();
  endtask
  // one clock: predict and check Pops, model the FIFO read, then check the output stage
  task automatic tick();
    int c;
    logic p, ei;
    logic [7:0] v;
    @(negedge clk);
    c = -1;
    for (int k = 0; k < 4; k++) if (c < 0 && fq[(m_g + k) % 4].size() > 0) c = (m_g + k) % 4;
    p = reset_L && !afull && c >= 0;
    chk("pops", pops, p ? 32'd1 << c : 32'd0);
    ei = c < 0 && !m_v1;
    if (p) begin
      sb.push_back(fq[c][0]);
      hist.push_back(c);
      if (c != m_g) m_cnt = 0;
      m_cnt++;
      if (m_cnt >= wt[c]) begin
        m_g = (c + 1) % 4;
        m_cnt = 0;
      end else m_g = c;
    end
    @(posedge clk);
    #1;
    if (p) begin
      v = fq[c].pop_front();
      fdo[c*8 +: 8] = v;
      emp[c] = fq[c].size() == 0;
    end
    m_v2 = m_v1;
    m_v1 = p;
    chk("valid", vout, m_v2);
    if (m_v2) begin
      if (sb.size() > 0) v = sb.pop_front();
      else v = 'x;
      chk("data", dout, v);
    end
    chk("idle", idl, ei);
  endtask
  initial begin
    int nv;
    rst_pulse();
    hist.delete();
    for (int ch = 0; ch < 4; ch++) load(ch, 12, ch << 4);
    for (int i = 0; i < 52; i++) tick();
    chk("t1_len", hist.size(), 48);
    for (int i = 0; i < 10; i++) chk("t1_order", hist[i], exp1[i]);
    hist.delete();
    load(2, 5, 8'h20);
    for (int i = 0; i < 8; i++) tick();
    chk("t2_len", hist.size(), 5);
    for (int i = 0; i < 5; i++) chk("t2_ch", hist[i], 2);
    chk("t2_idle", idl, 1);
    hist.delete();
    load(0, 1, 8'h05);
    load(1, 3, 8'h15);
    for (int i = 0; i < 8; i++) tick();
    chk("t3_len", hist.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", hist[i], i == 0 ? 0 : 1);
    rst_pulse();
    hist.delete();
    for (int ch = 0; ch < 4; ch++) load(ch, 8, 8'h80 | (ch << 4));
    for (int i = 0; i < 3; i++) tick();
    afull = 1'b1;
    #0 nv = int'(vout);
    for (int i = 0; i < 4; i++) begin
      tick();
      nv += int'(vout);
    end
    chk("bp_words", nv, 2);
    afull = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    chk("bp_len", hist.size(), 32);
    chk("bp_resume0", hist[3], 0);
    chk("bp_next1", hist[4], 1);
    load(1, 4, 8'h40);
    load(3, 4, 8'h60);
    for (int i = 0; i < 3; i++) tick();
    rst_pulse();
    hist.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_first", hist[0], 1);
    e1 = 4'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rot", pops1, 32'd1 << (k % 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
